// File: rtl/alu_pkg.sv
// Shared types for the bit-sliced ALU datapath: assembler/arranger state and index sizing.
package alu_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } asm_state_e;

   // Slice index width, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/slice_index_map.sv
// Maps a slice sequence number to its destination slot, honouring reversed slice order.
module slice_index_map
   import alu_pkg::*;
#(
   parameter int unsigned N_A = 2,
   parameter int unsigned IW  = idx_width(N_A)
) (
   input  logic [IW-1:0] idx_i,
   input  logic          rev_i,
   output logic [IW-1:0] slot_o
);

   localparam logic [IW-1:0] LAST = IW'(N_A - 1);

   assign slot_o = rev_i ? (LAST - idx_i) : idx_i;

endmodule

// File: rtl/output_assembler.sv
// Reassembles S-bit ALU slices into an N_A*S-bit result word with valid/ready on both sides.
// Define OUTPUT_ASSEMBLER_FLAGS_EN to build the zero/negative/carry flag registers.
module output_assembler
   import alu_pkg::*;
#(
   parameter int unsigned S   = 4,
   parameter int unsigned N_A = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             reverse,
   input  logic             slice_valid,
   output logic             slice_ready,
   input  logic [S-1:0]     slice_data,
   input  logic             slice_cout,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [N_A*S-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
);

   localparam int unsigned   W    = N_A * S;
   localparam int unsigned   IW   = idx_width(N_A);
   localparam logic [IW-1:0] LAST = IW'(N_A - 1);

   asm_state_e      state_q;
   logic [IW-1:0]   idx_q;
   logic            rev_q;
   logic [W-1:0]    acc_q;
   logic [W-1:0]    result_q;
   logic            valid_q;

   logic            accept;
   logic            complete;
   logic            rev_cur;
   logic [IW-1:0]   slot;
   logic [W-1:0]    word_d;

   assign slice_ready  = (state_q == COLLECT);
   assign accept       = slice_valid && slice_ready;
   assign complete     = accept && (idx_q == LAST) && !flush;
   // The first slice steers itself with the live reverse input; later slices use the latched copy.
   assign rev_cur      = (idx_q == '0) ? reverse : rev_q;

   slice_index_map #(
      .N_A (N_A),
      .IW  (IW)
   ) u_map (
      .idx_i  (idx_q),
      .rev_i  (rev_cur),
      .slot_o (slot)
   );

   always_comb begin
      word_d = acc_q;
      word_d[int'(slot)*S +: S] = slice_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         idx_q    <= '0;
         rev_q    <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (flush) begin
         state_q  <= COLLECT;
         idx_q    <= '0;
         acc_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  if (idx_q == '0) rev_q <= reverse;
                  if (idx_q == LAST) begin
                     idx_q    <= '0;
                     acc_q    <= '0;
                     result_q <= word_d;
                     valid_q  <= 1'b1;
                     state_q  <= HOLD;
                  end else begin
                     idx_q    <= idx_q + IW'(1);
                     acc_q    <= word_d;
                  end
               end
            end
            HOLD: begin
               if (result_ready) begin
                  valid_q <= 1'b0;
                  state_q <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;

`ifdef OUTPUT_ASSEMBLER_FLAGS_EN
   logic nz_acc_q;
   logic flag_z_q;
   logic flag_n_q;
   logic flag_c_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nz_acc_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else if (flush) begin
         nz_acc_q <= 1'b0;
      end else if (complete) begin
         nz_acc_q <= 1'b0;
         flag_z_q <= ~(nz_acc_q | (|slice_data));
         flag_n_q <= word_d[W-1];
         flag_c_q <= slice_cout;
      end else if (accept) begin
         nz_acc_q <= nz_acc_q | (|slice_data);
      end
   end

   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
   assign flag_c = flag_c_q;
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = slice_cout ^ complete;

   assign flag_z = 1'b0;
   assign flag_n = 1'b0;
   assign flag_c = 1'b0;
`endif

endmodule
